// File: rtl/time_keeper_alarm.sv
// Running HH:MM:SS timekeeper with alarm compare, ring control FSM and BCD digits.
// Build option: define SNOOZE_EN to add the snooze state and its minute counter.
module time_keeper_alarm #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int RING_SECS     = 60,
   parameter int SNOOZE_MIN    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adjust_mode,
   input  logic [1:0] adjusted,
   input  logic [4:0] time_hours_in,
   input  logic [5:0] time_minutes_in,
   input  logic [4:0] alarm_hours_in,
   input  logic [5:0] alarm_minutes_in,
   input  logic       alarm_enable,
   input  logic       dismiss,
   input  logic       snooze,
   output logic [4:0] time_hours_out,
   output logic [5:0] time_minutes_out,
   output logic [5:0] seconds_out,
   output logic [4:0] alarm_hours_out,
   output logic [5:0] alarm_minutes_out,
   output logic [2:0] hours_tens,
   output logic [3:0] hours_units,
   output logic [2:0] minutes_tens,
   output logic [3:0] minutes_units,
   output logic       alarm_ringing,
   output logic       sec_tick
);

   localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
   localparam int RING_W = $clog2(RING_SECS + 1);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);

   function automatic logic time_valid(input logic [4:0] h, input logic [5:0] m);
      return (h <= 5'd23) && (m <= 6'd59);
   endfunction

   logic [PRESC_W-1:0] presc;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc             <= '0;
         sec_tick          <= 1'b0;
         time_hours_out    <= '0;
         time_minutes_out  <= '0;
         seconds_out       <= '0;
         alarm_hours_out   <= '0;
         alarm_minutes_out <= '0;
      end else begin
         sec_tick <= 1'b0;
         if (adjust_mode) begin
            presc <= '0;
            if (adjusted[0] && time_valid(time_hours_in, time_minutes_in)) begin
               time_hours_out   <= time_hours_in;
               time_minutes_out <= time_minutes_in;
               seconds_out      <= '0;
            end
         end else if (presc == PRESC_MAX) begin
            // second boundary: tick and counters advance on the same edge
            presc    <= '0;
            sec_tick <= 1'b1;
            if (seconds_out == 6'd59) begin
               seconds_out <= '0;
               if (time_minutes_out == 6'd59) begin
                  time_minutes_out <= '0;
                  time_hours_out   <= (time_hours_out == 5'd23) ? 5'd0 : time_hours_out + 5'd1;
               end else begin
                  time_minutes_out <= time_minutes_out + 6'd1;
               end
            end else begin
               seconds_out <= seconds_out + 6'd1;
            end
         end else begin
            presc <= presc + PRESC_W'(1);
         end
         if (adjusted[1] && time_valid(alarm_hours_in, alarm_minutes_in)) begin
            alarm_hours_out   <= alarm_hours_in;
            alarm_minutes_out <= alarm_minutes_in;
         end
      end
   end

   assign hours_tens    = 3'(time_hours_out / 5'd10);
   assign hours_units   = 4'(time_hours_out % 5'd10);
   assign minutes_tens  = 3'(time_minutes_out / 6'd10);
   assign minutes_units = 4'(time_minutes_out % 6'd10);

   // sec_tick is high in the cycle the new time is visible, so the compare uses registered values
   logic match;
   assign match = sec_tick && (seconds_out == 6'd0) &&
                  (time_hours_out == alarm_hours_out) &&
                  (time_minutes_out == alarm_minutes_out) &&
                  alarm_enable && !adjust_mode;

`ifdef SNOOZE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;
   localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
   localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_MIN * 60 - 1);
   logic [SNZ_W-1:0] snz_cnt, snz_cnt_nxt;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, RINGING = 1'b1} state_t;
   logic unused_snooze;
   assign unused_snooze = snooze & (SNOOZE_MIN != 0);
`endif

   state_t state, state_nxt;
   logic [RING_W-1:0] ring_cnt, ring_cnt_nxt;
   logic stop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ring_cnt <= '0;
`ifdef SNOOZE_EN
         snz_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         ring_cnt <= ring_cnt_nxt;
`ifdef SNOOZE_EN
         snz_cnt  <= snz_cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      ring_cnt_nxt = ring_cnt;
`ifdef SNOOZE_EN
      snz_cnt_nxt  = snz_cnt;
`endif
      stop = dismiss || !alarm_enable || adjust_mode;
      case (state)
         IDLE: begin
            if (match && !dismiss) begin
               state_nxt    = RINGING;
               ring_cnt_nxt = '0;
            end
         end
         RINGING: begin
            if (stop) begin
               state_nxt = IDLE;
`ifdef SNOOZE_EN
            end else if (snooze) begin
               state_nxt   = SNOOZE;
               snz_cnt_nxt = '0;
`endif
            end else if (sec_tick) begin
               if (ring_cnt == RING_LAST) state_nxt = IDLE;
               else ring_cnt_nxt = ring_cnt + RING_W'(1);
            end
         end
`ifdef SNOOZE_EN
         SNOOZE: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (sec_tick) begin
               if (snz_cnt == SNZ_LAST) begin
                  state_nxt    = RINGING;
                  ring_cnt_nxt = '0;
               end else begin
                  snz_cnt_nxt = snz_cnt + SNZ_W'(1);
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   assign alarm_ringing = (state == RINGING);

endmodule
